// File: rtl/wave_tbl_seq.sv
// Wavetable address sequencer: walks a latched ROM address range with a per-entry
// dwell and optional looping, presenting each (sigA, sigB) entry on a valid/ready port.
module wave_tbl_seq #(
  parameter int A  = 4,
  parameter int D  = 16,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          stop,
  input  logic          loop_en,
  input  logic [A-1:0]  first_addr,
  input  logic [A-1:0]  last_addr,
  input  logic [CW-1:0] dwell,
  output logic [A-1:0]  tbl_addr,
  input  logic [D-1:0]  tbl_sigA,
  input  logic [D-1:0]  tbl_sigB,
  output logic [D-1:0]  out_sigA,
  output logic [D-1:0]  out_sigB,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy,
  output logic          done
);

  typedef enum logic [2:0] {IDLE, FETCH, EMIT, HOLD, DONE} state_t;

  state_t        state_q;
  logic [A-1:0]  addr_q, first_q, last_q;
  logic [CW-1:0] dwell_q, cnt_q;
  logic          loop_q;
  logic [D-1:0]  sa_q, sb_q;
  logic          valid_q, done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      first_q <= '0;
      last_q  <= '0;
      dwell_q <= '0;
      cnt_q   <= '0;
      loop_q  <= 1'b0;
      sa_q    <= '0;
      sb_q    <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      // Abort wins over any handshake or advance in the same cycle.
      if (state_q != IDLE && stop) begin
        state_q <= IDLE;
        valid_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: if (start) begin
            first_q <= first_addr;
            last_q  <= last_addr;
            dwell_q <= dwell;
            loop_q  <= loop_en;
            addr_q  <= first_addr;
            state_q <= FETCH;
          end
          FETCH: begin
            sa_q    <= tbl_sigA;
            sb_q    <= tbl_sigB;
            valid_q <= 1'b1;
            state_q <= EMIT;
          end
          EMIT: if (valid_q && out_ready) begin
            valid_q <= 1'b0;
            cnt_q   <= dwell_q;
            state_q <= HOLD;
          end
          HOLD: begin
            if (cnt_q != '0) begin
              cnt_q <= cnt_q - 1'b1;
            end else if (addr_q == last_q) begin
              if (loop_q) begin
                addr_q  <= first_q;
                state_q <= FETCH;
              end else begin
                done_q  <= 1'b1;
                state_q <= DONE;
              end
            end else begin
              addr_q  <= addr_q + 1'b1;
              state_q <= FETCH;
            end
          end
          DONE:    state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign tbl_addr  = addr_q;
  assign out_sigA  = sa_q;
  assign out_sigB  = sb_q;
  assign out_valid = valid_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;

endmodule

// File: tb/tb_wave_tbl_seq.sv
// Scoreboard bench for wave_tbl_seq: a task model of the address walk fills an
// expected-sample queue; a negedge monitor checks samples, timing and done.
module tb_wave_tbl_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, stop = 1'b0, loop_en = 1'b0;
  logic [3:0]  first_addr = '0, last_addr = '0;
  logic [15:0] dwell = '0;
  logic [3:0]  tbl_addr;
  logic [15:0] tbl_sigA, tbl_sigB, out_sigA, out_sigB;
  logic        out_valid, out_ready, busy, done;

  wave_tbl_seq #(.A(4), .D(16), .CW(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .loop_en(loop_en),
    .first_addr(first_addr), .last_addr(last_addr), .dwell(dwell),
    .tbl_addr(tbl_addr), .tbl_sigA(tbl_sigA), .tbl_sigB(tbl_sigB),
    .out_sigA(out_sigA), .out_sigB(out_sigB), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [3:0] a);
    case (a)
      4'h0: rom = 32'h1000_0000;
      4'h1: rom = 32'h0000_1000;
      4'h2: rom = 32'h1000_1000;
      4'h3: rom = 32'h2000_0000;
      4'h4: rom = 32'h0000_2000;
      4'h5: rom = 32'h2000_2000;
      4'h9: rom = 32'h1234_0000;
      4'hA: rom = 32'h0000_1234;
      4'hB: rom = 32'h1234_1234;
      4'hE: rom = 32'h1000_0000;
      4'hF: rom = 32'h1000_0000;
      default: rom = {4'h7, a, 8'h11, 4'h5, a, 8'h22};
    endcase
  endfunction

  logic [31:0] rom_w;
  assign rom_w    = rom(tbl_addr);
  assign tbl_sigA = rom_w[31:16];
  assign tbl_sigB = rom_w[15:0];

  typedef struct { logic [3:0] a; logic [15:0] sa; logic [15:0] sb; } exp_t;
  exp_t q[$];

  int n_chk = 0, n_fail = 0;
  int cyc = 0;
  int exp_vcyc = -1, exp_done = -1;
  int hs_cnt = 0;
  int cur_dwell = 0;
  bit cur_loop = 0;
  int rdy_mode = 0;
  logic man_ready = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (rdy_mode == 0)      out_ready = 1'b1;
    else if (rdy_mode == 1) out_ready = 1'($urandom_range(0, 1));
    else                    out_ready = man_ready;
  end

  // Monitor
  logic        prev_v = 0, prev_r = 0, prev_stop = 0;
  logic [3:0]  prev_a = 0;
  logic [15:0] prev_sa = 0, prev_sb = 0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_v = 0;
    end else begin
      if (start && !busy) exp_vcyc = cyc + 2;
      if (out_valid && !prev_v) chk("valid_time", cyc, exp_vcyc);
      if (prev_v && !prev_r && !prev_stop) begin
        chk("hold_valid", out_valid, 1'b1);
        chk("hold_addr", tbl_addr, prev_a);
        chk("hold_sigA", out_sigA, prev_sa);
        chk("hold_sigB", out_sigB, prev_sb);
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_sample", 1, 0);
        end else begin
          e = q.pop_front();
          chk("addr", tbl_addr, e.a);
          chk("sigA", out_sigA, e.sa);
          chk("sigB", out_sigB, e.sb);
          if (q.size() == 0 && !cur_loop) exp_done = cyc + cur_dwell + 2;
          else exp_vcyc = cyc + cur_dwell + 3;
        end
        hs_cnt++;
      end
      if (done || cyc == exp_done) chk("done", done, cyc == exp_done);
      if (exp_done >= 0 && cyc == exp_done + 1) chk("busy_after_done", busy, 1'b0);
      prev_v = out_valid; prev_r = out_ready; prev_stop = stop;
      prev_a = tbl_addr; prev_sa = out_sigA; prev_sb = out_sigB;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push_addr(input logic [3:0] a);
    exp_t e;
    e.a = a; e.sa = rom(a) >> 16; e.sb = rom(a) & 32'hFFFF;
    q.push_back(e);
  endtask

  // Model: expected entries for one run; loop runs get n entries of the cycle.
  task automatic run_start(input logic [3:0] f, input logic [3:0] l, input int d,
                           input bit lp, input int n);
    int a = f;
    q.delete();
    exp_done = -1;
    cur_dwell = d; cur_loop = lp;
    if (lp) begin
      for (int i = 0; i < n; i++) begin
        push_addr(4'(a));
        a = (a == l) ? f : (a + 1) % 16;
      end
    end else begin
      forever begin
        push_addr(4'(a));
        if (a == l) break;
        a = (a + 1) % 16;
      end
    end
    first_addr = f; last_addr = l; dwell = 16'(d); loop_en = lp;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 3000) begin tick(); k++; end
    chk("idle_timeout", busy, 1'b0);
    repeat (3) tick();
    chk("queue_drained", q.size(), 0);
  endtask

  task automatic wait_valid();
    int k = 0;
    while (!out_valid && k < 100) begin tick(); k++; end
    chk("valid_timeout", out_valid, 1'b1);
  endtask

  initial begin
    int base;
    #23;
    chk("rst_addr", tbl_addr, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sigA", out_sigA, 0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Basic range, no wrap
    rdy_mode = 0;
    run_start(4'h0, 4'h2, 0, 0, 0);
    wait_idle();

    // Backpressure on the first sample
    rdy_mode = 2; man_ready = 1'b0;
    repeat (2) tick();
    run_start(4'h0, 4'h2, 0, 0, 0);
    wait_valid();
    repeat (4) tick();
    man_ready = 1'b1;
    wait_idle();
    rdy_mode = 0;

    // Dwell
    run_start(4'h3, 4'h5, 5, 0, 0);
    wait_idle();

    // Address wrap
    run_start(4'hE, 4'h1, 0, 0, 0);
    wait_idle();

    // Loop, start-while-busy, abort in HOLD
    base = hs_cnt;
    run_start(4'h9, 4'hB, 1, 1, 12);
    while (hs_cnt < base + 2) tick();
    first_addr = 4'h0; last_addr = 4'h0; dwell = 16'd0; loop_en = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 0; k < 200 && hs_cnt < base + 7; k++) tick();
    chk("loop_samples", hs_cnt - base, 7);
    stop = 1'b1; tick(); stop = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_valid", out_valid, 0);
    repeat (5) tick();
    chk("abort_no_done", done, 0);
    q.delete();

    // Randomized runs
    for (int r = 0; r < 6; r++) begin
      rdy_mode = 1;
      run_start(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                $urandom_range(0, 3), 0, 0);
      wait_idle();
    end
    rdy_mode = 0;

    // Async reset mid-EMIT
    rdy_mode = 2; man_ready = 1'b0;
    repeat (2) tick();
    run_start(4'h3, 4'h5, 0, 0, 0);
    wait_valid();
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_addr", tbl_addr, 0);
    chk("arst_busy", busy, 0);
    q.delete(); exp_vcyc = -1; exp_done = -1;
    repeat (2) tick();
    rst_n = 1'b1;
    man_ready = 1'b1;
    repeat (6) tick();
    chk("post_rst_idle_busy", busy, 0);
    chk("post_rst_idle_valid", out_valid, 0);
    rdy_mode = 0;
    run_start(4'h2, 4'h4, 0, 0, 0);
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/wave_tbl_seq.md
Name: wave_tbl_seq

Overview:
Sequencer for the dual-channel wavetable ROM (4-bit address, two 16-bit signals). It steps the ROM address through a programmed range, with a programmable dwell per entry and optional looping. Each ROM entry (sigA, sigB) is registered and presented downstream on a valid/ready interface. It sits between the control/config logic and the waveform consumer, and is the sole driver of the table address.

Parameters:
A, 4, table address width
D, 16, sample width of each channel
CW, 16, dwell counter width

Ports:
clk  in  1  single clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin sequence; sampled in IDLE only
stop  in  1  abort sequence; sampled in any non-IDLE state
loop_en  in  1  restart at first_addr after last_addr; latched at start
first_addr  in  A  first table entry; latched at start
last_addr  in  A  final table entry; latched at start
dwell  in  CW  extra idle cycles after each accepted sample; latched at start
tbl_addr  out  A  address to wavetable ROM (registered)
tbl_sigA  in  D  ROM channel A data (combinational from tbl_addr)
tbl_sigB  in  D  ROM channel B data
out_sigA  out  D  registered channel A sample
out_sigB  out  D  registered channel B sample
out_valid  out  1  sample valid
out_ready  in  1  consumer accepts sample
busy  out  1  state != IDLE
done  out  1  one-cycle pulse on normal (non-aborted) completion

Behaviour:
- Reset (rst_n low, async): state IDLE; tbl_addr, out_sigA, out_sigB, cnt, and latched config = 0; out_valid, busy, done = 0.
- States: IDLE, FETCH, EMIT, HOLD, DONE.
- IDLE: if start is high, latch first/last/dwell/loop_en and set tbl_addr <= first_addr -> FETCH. Otherwise stay in IDLE.
- FETCH (1 cycle): out_sigA <= tbl_sigA, out_sigB <= tbl_sigB, out_valid <= 1 -> EMIT.
- EMIT: out_sigA, out_sigB, out_valid, and tbl_addr are held stable until out_valid && out_ready.
  - On handshake: out_valid <= 0, cnt <= dwell -> HOLD.
- HOLD: when cnt != 0, decrement cnt. When cnt == 0, advance:
  - If tbl_addr == last: with loop, tbl_addr <= first -> FETCH; without loop -> DONE.
  - Otherwise tbl_addr <= tbl_addr + 1, modulo 2^A -> FETCH.
- DONE: done = 1 for exactly this cycle -> IDLE. tbl_addr retains last_addr.
- Timing:
  - First out_valid is asserted 2 cycles after the start edge.
  - With out_ready held high, the sample period is dwell + 3 cycles.
  - done is asserted 2 cycles after the final handshake when dwell = 0.
- first > last: the address wraps through 2^A-1 -> 0 until it equals last. first == last: single-entry sequence.
- stop in any non-IDLE state: next edge -> IDLE, out_valid <= 0, no done pulse, tbl_addr holds. stop has priority over a simultaneous handshake or advance.
- start while busy is ignored. start and stop in IDLE on the same cycle: start wins, because stop is not sampled in IDLE.
- Config input changes while busy have no effect until the next start.
- busy is combinational from state. done is registered, derived from state == DONE.

Test Plan:
- Basic range, no wrap:
  - Stimulus: first=0, last=2, dwell=0, loop=0, ready=1, start pulse.
  - Required: valid samples (A,B) = (1000,0000), (0000,1000), (1000,1000) at cycles 2, 5, 8 after start; done pulses at cycle 10; busy is low from cycle 11.
- Backpressure:
  - Stimulus: same setup, with ready held low for 4 cycles on the first sample.
  - Required: out_valid stays high and out_sigA=1000 / tbl_addr=0 stay stable; the second sample appears 3 cycles after ready rises.
- Dwell:
  - Stimulus: first=3, last=5, dwell=5, ready=1.
  - Required: samples (2000,0000), (0000,2000), (2000,2000) spaced 8 cycles apart.
- Address wrap:
  - Stimulus: first=E, last=1, loop=0.
  - Required: tbl_addr sequence E, F, 0, 1; samples (1000,0000)x3 then (0000,1000); then done.
- Loop and abort:
  - Stimulus: first=9, last=B, loop=1; run 7 samples, then pulse stop during HOLD.
  - Required: samples (1234,0000), (0000,1234), (1234,1234) repeat in order; after stop, busy=0 and out_valid=0 on the next cycle, with no done pulse. A start pulse issued while busy must be ignored.
- Async reset:
  - Stimulus: drop rst_n mid-EMIT between clock edges.
  - Required: outputs clear immediately (out_valid=0, tbl_addr=0, busy=0); after release, the block idles until start.
